uxn_screen_cmd_encoder: RTL
===========================

Name: uxn_screen_cmd_encoder

Overview:
- Upstream feeder of the draw queue. Decodes Varvara screen-device port writes from the Uxn CPU into 24-bit draw-queue words on `queue_data`/`queue_we`.
- Owns the screen x/y/addr/auto registers.
- Expands auto-length sprite commands into one 2-word queue entry per sprite.

Parameters:
SCREEN_W, 320, visible width; pixels/sprites with x >= SCREEN_W are not emitted (fill clamps instead)
SCREEN_H, 288, visible height; same rule for y

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dev_we  in  1  screen device port write strobe (one cycle per byte)
dev_port  in  4  port low nibble: 6 auto, 8/9 x hi/lo, A/B y hi/lo, C/D addr hi/lo, E pixel, F sprite; others ignored
dev_wdata  in  8  write byte
x_out  out  16  current x register (CPU readback)
y_out  out  16  current y register
addr_out  out  16  current sprite address register
busy  out  1  high while a sprite command expands; CPU must not write while high
queue_we  out  1  one-cycle write strobe into the draw queue
queue_data  out  24  queue word

Behaviour:
- Async reset (reset_n low): x, y, addr, auto, all outputs = 0; state IDLE. Reset mid-sprite abandons the remaining words.
- Word 0 layout: [23] layer, [22:21] color lo, [20] fill, [19] fill: flip-y / sprite: 1, [18] fill: flip-x / sprite: 2bpp, [17:9] x, [8:0] y.
- Word 1 layout (sprites only): [19] fy, [18] fx, [17:16] color hi, [15:0] addr.
- Register writes take effect in the cycle after dev_we. Hi/lo bytes update only their half.
- Writes to any port while busy = 1 are ignored.
- Pixel byte fields: [7] fill, [6] layer, [5] flip-y, [4] flip-x, [1:0] color.
- Pixel, non-fill:
  - Emitted one cycle after the write (queue_we = 1 for one cycle) only if x < SCREEN_W and y < SCREEN_H.
  - Afterwards x += auto[0], y += auto[1]. This update is applied even when the pixel is not emitted.
  - Word {layer,color,0,0,0,x[8:0],y[8:0]} == 0 is replaced by 0x1C0000 (degenerate 1x1 fill at 0,0). The queue treats an all-zero word as empty.
- Pixel, fill:
  - Coordinates clamp to 319/287 when the corresponding flip bit is set.
  - Skipped if a coordinate is off-screen and its flip bit is clear.
  - No auto update; latency 1.
- Sprite byte fields: [7] 2bpp, [6] layer, [5] fy, [4] fx, [3:0] color.
- Sprite expansion:
  - len = auto[7:4]; dx = auto[0] ? 8 : 0, negated if fx; dy = auto[1] ? 8 : 0, negated if fy; all arithmetic 16-bit wrap.
  - Sprite i (0..len) is drawn at (x + dy*i, y + dx*i).
  - State machine: IDLE -> W0 -> W1 -> (W0 if i < len, else IDLE).
  - W0 drives word 0, W1 drives word 1; one word per cycle, back to back.
  - A sprite off-screen (x >= SCREEN_W or y >= SCREEN_H, 16-bit unsigned) still occupies its W0/W1 cycles with queue_we = 0.
  - After each W1: addr += auto[2] ? (2bpp ? 16 : 8) : 0.
  - On the final W1: x += dx, y += dy.
  - busy rises the cycle after the sprite write and falls the cycle after the final W1. Total busy = 2*(len+1) cycles.
- No backpressure: the downstream queue accepts every strobe.

Test Plan:
- Pixel: reset, x = 10, y = 20, write E = 0x41 -> next cycle queue_we = 1, data = 0xA01414; x_out stays 10.
- Zero pixel: x = 0, y = 0, E = 0x00 -> data = 0x1C0000.
- Fill: x = 100, y = 50, E = 0xB2 -> data = 0x5CC832. Repeat with x = 400, E = 0x82 -> no strobe.
- Auto sprite: x = 16, y = 8, addr = 0x1234, auto = 0x15, F = 0x81 -> words 0x2C2008, 0x001234, 0x2C2010, 0x001244 on 4 consecutive cycles; busy high exactly those 4 cycles; afterwards x_out = 24, y_out = 8, addr_out = 0x1254.
- Clip/ignore: x = 0xFFFC, F = 0x01 -> busy 2 cycles, no strobe. A write to port 8 during busy does not change x.
- Reset mid-sprite: assert reset_n low during a W1 of a len = 3 sprite -> all outputs 0 immediately; no further strobes after release.

Source files
------------

// File: rtl/uxn_screen_cmd_encoder.sv
// ---------------------------------------------------------------------------
// uxn_screen_cmd_encoder
//
// Turns Varvara screen-device port writes from the Uxn CPU into 24-bit
// draw-queue words. This block owns the screen x/y/addr/auto registers.
// A pixel write produces at most one queue word. A sprite write produces
// two words (W0, W1) for each sprite of an auto-length run.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   dev_we      device port write strobe (one cycle per byte)
//   dev_port    port low nibble: 6 auto, 8/9 x hi/lo, A/B y hi/lo,
//               C/D addr hi/lo, E pixel, F sprite; other values ignored
//   dev_wdata   write byte
//   x_out       current x register
//   y_out       current y register
//   addr_out    current sprite address register
//   busy        high while a sprite run expands; writes are ignored
//   queue_we    one-cycle write strobe into the draw queue
//   queue_data  queue word
// ---------------------------------------------------------------------------
module uxn_screen_cmd_encoder #(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 288
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dev_we,
   input  logic [3:0]  dev_port,
   input  logic [7:0]  dev_wdata,
   output logic [15:0] x_out,
   output logic [15:0] y_out,
   output logic [15:0] addr_out,
   output logic        busy,
   output logic        queue_we,
   output logic [23:0] queue_data
);

   localparam logic [15:0] W16   = 16'(SCREEN_W);
   localparam logic [15:0] H16   = 16'(SCREEN_H);
   localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
   localparam logic [15:0] Y_MAX = 16'(SCREEN_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_W0, S_W1} state_t;

   state_t      state_q;
   logic [15:0] x_q, y_q, addr_q;
   logic [3:0]  auto_len_q;     // auto[7:4]
   logic [2:0]  auto_mode_q;    // auto[2:0]: addr step, y step, x step
   logic [7:0]  spr_ctl_q;      // latched sprite byte
   logic [15:0] spr_x_q, spr_y_q;
   logic [3:0]  spr_idx_q;
   logic        busy_q;
   logic        queue_we_q;
   logic [23:0] queue_data_q;

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   function automatic logic on_screen(input logic [15:0] px, input logic [15:0] py);
      return (px < W16) && (py < H16);
   endfunction

   function automatic logic [23:0] sprite_w0(input logic [7:0] ctl,
                                             input logic [8:0] px,
                                             input logic [8:0] py);
      return {ctl[6], ctl[1:0], 1'b0, 1'b1, ctl[7], px, py};
   endfunction

   function automatic logic [23:0] sprite_w1(input logic [7:0] ctl,
                                             input logic [15:0] a);
      return {4'b0000, ctl[5], ctl[4], ctl[3:2], a};
   endfunction

   // ---------------------------------------------------------------------
   // Pixel command decode (valid while dev_wdata carries a port E byte)
   // ---------------------------------------------------------------------
   logic        pix_fill, pix_layer, pix_fy, pix_fx;
   logic [1:0]  pix_color;
   logic        x_on, y_on;
   logic [15:0] fill_x, fill_y;
   logic        fill_ok, dot_ok;
   logic [23:0] fill_word, dot_raw, dot_word;

   assign pix_fill  = dev_wdata[7];
   assign pix_layer = dev_wdata[6];
   assign pix_fy    = dev_wdata[5];
   assign pix_fx    = dev_wdata[4];
   assign pix_color = dev_wdata[1:0];

   assign x_on = (x_q < W16);
   assign y_on = (y_q < H16);

   // A fill whose origin is past the edge starts at the last row/column when
   // it extends back towards the screen; otherwise it has nothing to cover.
   assign fill_x    = (!x_on && pix_fx) ? X_MAX : x_q;
   assign fill_y    = (!y_on && pix_fy) ? Y_MAX : y_q;
   assign fill_ok   = (x_on || pix_fx) && (y_on || pix_fy);
   assign fill_word = {pix_layer, pix_color, 1'b1, pix_fy, pix_fx, fill_x[8:0], fill_y[8:0]};

   // An all-zero word means "empty" to the queue, so a background colour-0
   // dot at (0,0) is sent as the equivalent 1x1 fill.
   assign dot_ok   = x_on && y_on;
   assign dot_raw  = {pix_layer, pix_color, 3'b000, x_q[8:0], y_q[8:0]};
   assign dot_word = (dot_raw == 24'h0) ? 24'h1C0000 : dot_raw;

   // ---------------------------------------------------------------------
   // Sprite run stepping
   // ---------------------------------------------------------------------
   logic [15:0] step_x, step_y, addr_step;
   logic [15:0] nxt_x, nxt_y;
   logic        last_sprite;

   assign step_x    = auto_mode_q[0] ? (spr_ctl_q[4] ? 16'hFFF8 : 16'h0008) : 16'h0000;
   assign step_y    = auto_mode_q[1] ? (spr_ctl_q[5] ? 16'hFFF8 : 16'h0008) : 16'h0000;
   assign addr_step = auto_mode_q[2] ? (spr_ctl_q[7] ? 16'h0010 : 16'h0008) : 16'h0000;

   // Auto-x stacks the run downwards and auto-y stacks it across, so the
   // per-sprite offsets are swapped relative to the final x/y update.
   assign nxt_x       = spr_x_q + step_y;
   assign nxt_y       = spr_y_q + step_x;
   assign last_sprite = (spr_idx_q >= auto_len_q);

   // ---------------------------------------------------------------------
   // Main state machine and register file
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         x_q          <= 16'h0;
         y_q          <= 16'h0;
         addr_q       <= 16'h0;
         auto_len_q   <= 4'h0;
         auto_mode_q  <= 3'h0;
         spr_ctl_q    <= 8'h0;
         spr_x_q      <= 16'h0;
         spr_y_q      <= 16'h0;
         spr_idx_q    <= 4'h0;
         busy_q       <= 1'b0;
         queue_we_q   <= 1'b0;
         queue_data_q <= 24'h0;
      end else begin
         queue_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (dev_we) begin
                  case (dev_port)
                     4'h6: begin
                        auto_len_q  <= dev_wdata[7:4];
                        auto_mode_q <= dev_wdata[2:0];
                     end
                     4'h8: x_q[15:8]    <= dev_wdata;
                     4'h9: x_q[7:0]     <= dev_wdata;
                     4'hA: y_q[15:8]    <= dev_wdata;
                     4'hB: y_q[7:0]     <= dev_wdata;
                     4'hC: addr_q[15:8] <= dev_wdata;
                     4'hD: addr_q[7:0]  <= dev_wdata;
                     4'hE: begin
                        if (pix_fill) begin
                           queue_we_q   <= fill_ok;
                           queue_data_q <= fill_word;
                        end else begin
                           queue_we_q   <= dot_ok;
                           queue_data_q <= dot_word;
                           // Auto-advance happens whether or not the dot was visible.
                           x_q <= x_q + {15'h0, auto_mode_q[0]};
                           y_q <= y_q + {15'h0, auto_mode_q[1]};
                        end
                     end
                     4'hF: begin
                        // Word 0 of sprite 0 goes out together with busy rising.
                        spr_ctl_q    <= dev_wdata;
                        spr_x_q      <= x_q;
                        spr_y_q      <= y_q;
                        spr_idx_q    <= 4'h0;
                        queue_we_q   <= on_screen(x_q, y_q);
                        queue_data_q <= sprite_w0(dev_wdata, x_q[8:0], y_q[8:0]);
                        busy_q       <= 1'b1;
                        state_q      <= S_W0;
                     end
                     default: ;
                  endcase
               end
            end

            S_W0: begin
               queue_we_q   <= on_screen(spr_x_q, spr_y_q);
               queue_data_q <= sprite_w1(spr_ctl_q, addr_q);
               state_q      <= S_W1;
            end

            S_W1: begin
               addr_q <= addr_q + addr_step;
               if (!last_sprite) begin
                  spr_idx_q    <= spr_idx_q + 4'h1;
                  spr_x_q      <= nxt_x;
                  spr_y_q      <= nxt_y;
                  queue_we_q   <= on_screen(nxt_x, nxt_y);
                  queue_data_q <= sprite_w0(spr_ctl_q, nxt_x[8:0], nxt_y[8:0]);
                  state_q      <= S_W0;
               end else begin
                  x_q     <= x_q + step_x;
                  y_q     <= y_q + step_y;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign x_out      = x_q;
   assign y_out      = y_q;
   assign addr_out   = addr_q;
   assign busy       = busy_q;
   assign queue_we   = queue_we_q;
   assign queue_data = queue_data_q;

endmodule
